// File: rtl/alu_exec_unit_pkg.sv
// Shared RV32I opcode/funct3 constants and the 4-bit ALU operation encoding.
package alu_exec_unit_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

  localparam logic [2:0] FNC_ADD_SUB = 3'b000;
  localparam logic [2:0] FNC_SLL     = 3'b001;
  localparam logic [2:0] FNC_SLT     = 3'b010;
  localparam logic [2:0] FNC_SLTU    = 3'b011;
  localparam logic [2:0] FNC_XOR     = 3'b100;
  localparam logic [2:0] FNC_SRL_SRA = 3'b101;
  localparam logic [2:0] FNC_OR      = 3'b110;
  localparam logic [2:0] FNC_AND     = 3'b111;

  localparam logic FNC2_SRL = 1'b0;
  localparam logic FNC2_SRA = 1'b1;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_B = 4'd10,
    ALU_NOP    = 4'd15
  } alu_op_e;

endpackage

// File: rtl/alu_exec_unit_alu_op_decoder.sv
// Combinational opcode/funct3/bit30 -> ALU operation decoder.
// Shift encodings decode to NOP unless ALU_SHIFT_EN is defined.
module alu_op_decoder
  import alu_exec_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct,
  input  logic       add_rshift_type,
  output alu_op_e    alu_op
);

  always_comb begin
    alu_op = ALU_NOP;
    case (opcode)
      OPC_LUI: alu_op = ALU_COPY_B;
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE:
        alu_op = ALU_ADD;
      OPC_ARI_ITYPE, OPC_ARI_RTYPE: begin
        case (funct)
          // Immediate forms have no SUBI: bit 30 is part of the immediate there.
          FNC_ADD_SUB: alu_op = (opcode == OPC_ARI_RTYPE && add_rshift_type) ? ALU_SUB : ALU_ADD;
          FNC_SLT:     alu_op = ALU_SLT;
          FNC_SLTU:    alu_op = ALU_SLTU;
          FNC_XOR:     alu_op = ALU_XOR;
          FNC_OR:      alu_op = ALU_OR;
          FNC_AND:     alu_op = ALU_AND;
`ifdef ALU_SHIFT_EN
          FNC_SLL:     alu_op = ALU_SLL;
          FNC_SRL_SRA: alu_op = (add_rshift_type == FNC2_SRA) ? ALU_SRA : ALU_SRL;
`else
          FNC_SLL:     alu_op = ALU_NOP;
          FNC_SRL_SRA: alu_op = ALU_NOP;
`endif
          default:     alu_op = ALU_NOP;
        endcase
      end
      default: alu_op = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I execute block: decoder, combinational ALU and one-cycle result register.
// Optional barrel shifter enabled by defining ALU_SHIFT_EN.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct,
  input  logic                  add_rshift_type,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [3:0]            ALUop,
  output logic [DATA_WIDTH-1:0] Out,
  output logic                  Zero,
  output logic [DATA_WIDTH-1:0] OutReg,
  output logic                  ZeroReg
);

  alu_op_e                      alu_op;
  logic signed [DATA_WIDTH-1:0] a_s;
  logic signed [DATA_WIDTH-1:0] b_s;
`ifdef ALU_SHIFT_EN
  logic [4:0]                   shamt;
  assign shamt = B[4:0];
`endif

  alu_op_decoder u_dec (
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .alu_op          (alu_op)
  );

  assign ALUop = alu_op;
  assign a_s   = A;
  assign b_s   = B;

  // Stage 0: combinational datapath; unused codes 11-14 fall to zero like NOP.
  always_comb begin
    Out = '0;
    case (alu_op)
      ALU_ADD:    Out = A + B;
      ALU_SUB:    Out = A - B;
      ALU_SLT:    Out = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:   Out = {{(DATA_WIDTH-1){1'b0}}, (A < B)};
      ALU_XOR:    Out = A ^ B;
      ALU_OR:     Out = A | B;
      ALU_AND:    Out = A & B;
      ALU_COPY_B: Out = B;
`ifdef ALU_SHIFT_EN
      ALU_SLL:    Out = A << shamt;
      ALU_SRL:    Out = A >> shamt;
      ALU_SRA:    Out = $unsigned(a_s >>> shamt);
`endif
      default:    Out = '0;
    endcase
  end

  assign Zero = (Out == '0);

  // Stage 1: writeback copy; reset value mirrors a zero result.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutReg  <= '0;
      ZeroReg <= 1'b1;
    end else begin
      OutReg  <= Out;
      ZeroReg <= Zero;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues hand-computed results, a monitor checks them.
module tb_alu_exec_unit;

  logic        Clock;
  logic        Reset;
  logic [6:0]  opcode;
  logic [2:0]  funct;
  logic        add_rshift_type;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUop;
  logic [31:0] Out;
  logic        Zero;
  logic [31:0] OutReg;
  logic        ZeroReg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] out;
    logic        zero;
    bit          chk_reg;
    logic [31:0] oreg;
    logic        zreg;
  } exp_t;

  exp_t queue_exp[$];
  event sample_ev;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .opcode          (opcode),
    .funct           (funct),
    .add_rshift_type (add_rshift_type),
    .A               (A),
    .B               (B),
    .ALUop           (ALUop),
    .Out             (Out),
    .Zero            (Zero),
    .OutReg          (OutReg),
    .ZeroReg         (ZeroReg)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: whenever the driver signals a sample point, check everything queued.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      while (queue_exp.size() > 0) begin
        e = queue_exp.pop_front();
        cmp(e.name, "ALUop", {28'd0, ALUop}, {28'd0, e.op});
        cmp(e.name, "Out", Out, e.out);
        cmp(e.name, "Zero", {31'd0, Zero}, {31'd0, e.zero});
        if (e.chk_reg) begin
          cmp(e.name, "OutReg", OutReg, e.oreg);
          cmp(e.name, "ZeroReg", {31'd0, ZeroReg}, {31'd0, e.zreg});
        end
      end
    end
  end

  task automatic apply(input logic [6:0] opc, input logic [2:0] f, input logic b30,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = opc;
    funct = f;
    add_rshift_type = b30;
    A = a;
    B = b;
  endtask

  task automatic expect_now(input string name, input logic [3:0] op, input logic [31:0] out,
                            input logic zero, input bit chk_reg, input logic [31:0] oreg,
                            input logic zreg);
    exp_t e;
    e.name = name; e.op = op; e.out = out; e.zero = zero;
    e.chk_reg = chk_reg; e.oreg = oreg; e.zreg = zreg;
    queue_exp.push_back(e);
    ->sample_ev;
    #3;
  endtask

  task automatic vec(input string name, input logic [6:0] opc, input logic [2:0] f, input logic b30,
                     input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                     input logic [31:0] out);
    @(negedge Clock);
    apply(opc, f, b30, a, b);
    expect_now(name, op, out, (out == 32'd0), 1'b0, 32'd0, 1'b0);
  endtask

  task automatic shift_vec(input string name, input logic [6:0] opc, input logic [2:0] f,
                           input logic b30, input logic [31:0] b, input logic [3:0] op_en,
                           input logic [31:0] out_en);
`ifdef ALU_SHIFT_EN
    vec(name, opc, f, b30, 32'hF000FFFF, b, op_en, out_en);
`else
    vec(name, opc, f, b30, 32'hF000FFFF, b, 4'd15, 32'd0);
`endif
  endtask

  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;

  initial begin
    Reset = 1'b1;
    apply(7'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    #2;
    expect_now("reset_state", 4'd15, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1);
    @(negedge Clock);
    Reset = 1'b0;

    vec("add_r",  RT, 3'b000, 1'b0, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008);
    vec("sub_r",  RT, 3'b000, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd1, 32'h80008002);
    vec("addi_b30", IT, 3'b000, 1'b1, 32'h80000005, 32'hFFFF8003, 4'd0, 32'h7FFF8008);
    vec("slt_neg", RT, 3'b010, 1'b0, 32'h80000005, 32'hFFFF8003, 4'd3, 32'd1);
    vec("sltu_big", RT, 3'b011, 1'b0, 32'h80000005, 32'hFFFF8003, 4'd4, 32'd1);
    vec("slti_1_m1", IT, 3'b010, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd3, 32'd0);
    vec("sltiu_1_m1", IT, 3'b011, 1'b0, 32'h00000001, 32'hFFFFFFFF, 4'd4, 32'd1);
    vec("lui",    7'b0110111, 3'b101, 1'b1, 32'h12345678, 32'hABCDE000, 4'd10, 32'hABCDE000);
    vec("auipc",  7'b0010111, 3'b011, 1'b1, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("load",   7'b0000011, 3'b010, 1'b0, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("store",  7'b0100011, 3'b001, 1'b1, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("branch", 7'b1100011, 3'b111, 1'b1, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("jalr",   7'b1100111, 3'b000, 1'b1, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("jal",    7'b1101111, 3'b101, 1'b0, 32'h12345678, 32'hABCDE000, 4'd0, 32'hBE023678);
    vec("xori",   IT, 3'b100, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd5, 32'hF00FF00F);
    vec("or_r",   RT, 3'b110, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd8, 32'hFF0FFF0F);
    vec("and_b30", RT, 3'b111, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 4'd9, 32'h0F000F00);

    shift_vec("sra_r",  RT, 3'b101, 1'b1, 32'h0000000F, 4'd7, 32'hFFFFE001);
    shift_vec("srl_r",  RT, 3'b101, 1'b0, 32'h0000000F, 4'd6, 32'h0001E001);
    shift_vec("sll_r",  RT, 3'b001, 1'b0, 32'h0000000F, 4'd2, 32'h7FFF8000);
    shift_vec("srai_hi", IT, 3'b101, 1'b1, 32'hFFFFFFEF, 4'd7, 32'hFFFFE001);
    shift_vec("srli_hi", IT, 3'b101, 1'b0, 32'hFFFFFFEF, 4'd6, 32'h0001E001);
    shift_vec("slli_hi", IT, 3'b001, 1'b0, 32'hFFFFFFEF, 4'd2, 32'h7FFF8000);

    vec("unknown_opc", 7'b1111111, 3'b000, 1'b1, 32'h12345678, 32'hABCDE000, 4'd15, 32'd0);
    vec("pre_reg_and", RT, 3'b111, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 4'd9, 32'h0F000F00);

    // Register timing: zero result captured on the next edge, OR result one edge later.
    @(negedge Clock);
    apply(RT, 3'b100, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    expect_now("xor_zero", 4'd5, 32'd0, 1'b1, 1'b1, 32'h0F000F00, 1'b0);
    @(negedge Clock);
    expect_now("xor_reg", 4'd5, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1);
    @(negedge Clock);
    apply(RT, 3'b110, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    expect_now("or_comb", 4'd8, 32'h5A5A5A5A, 1'b0, 1'b1, 32'd0, 1'b1);
    @(negedge Clock);
    expect_now("or_reg", 4'd8, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);

    // Asynchronous reset mid-cycle, combinational path unaffected.
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    expect_now("async_rst", 4'd8, 32'h5A5A5A5A, 1'b0, 1'b1, 32'd0, 1'b1);
    apply(7'b1111111, 3'b110, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    expect_now("rst_unknown", 4'd15, 32'd0, 1'b1, 1'b1, 32'd0, 1'b1);
    @(negedge Clock);
    apply(RT, 3'b110, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    expect_now("rst_held", 4'd8, 32'h5A5A5A5A, 1'b0, 1'b1, 32'd0, 1'b1);
    Reset = 1'b0;
    @(negedge Clock);
    expect_now("post_rst_load", 4'd8, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);

    for (int i = 0; i < 20 && queue_exp.size() != 0; i++) @(negedge Clock);
    if (queue_exp.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: got %0d pending expected 0", queue_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- 32-bit RV32I integer execute block: combined ALU decoder and ALU datapath.
- Maps opcode/funct3/funct7-bit to an internal 4-bit ALU op, then computes Out and Zero combinationally from A and B.
- Also provides a one-cycle registered copy of the result for the pipeline's writeback stage.
- Operand muxing (PC/rs1, imm/rs2) is done upstream.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- opcode  in  7  instruction bits [6:0]
- funct  in  3  instruction funct3
- add_rshift_type  in  1  instruction bit 30 (SUB/SRA select)
- A  in  32  operand A (rs1 or PC)
- B  in  32  operand B (rs2 or immediate, already sign-extended/shifted)
- ALUop  out  4  decoded operation
- Out  out  32  combinational result
- Zero  out  1  combinational, 1 when Out == 0
- OutReg  out  32  Out registered on Clock
- ZeroReg  out  1  Zero registered on Clock

Behaviour:
- ALUop encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, COPY_B=10, NOP=15; codes 11-14 are unused and behave as NOP.
- Opcode decode:
  - LUI 0110111 -> COPY_B
  - AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011 -> ADD; funct and add_rshift_type are ignored.
  - ARI_ITYPE 0010011, by funct3:
    - 000 ADD always; add_rshift_type is ignored, there is no SUBI.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
    - 101 -> SRL if add_rshift_type=0, SRA if 1.
  - ARI_RTYPE 0110011: same as ARI_ITYPE, except funct3 000 gives ADD if add_rshift_type=0 and SUB if 1.
  - Any other opcode -> NOP.
- Arithmetic (all modulo 2^32, no overflow flag):
  - ADD A+B; SUB A-B.
  - SLT = {31'b0, signed A < signed B}; SLTU = {31'b0, A < B}.
  - SLL A << B[4:0]; SRL logical A >> B[4:0]; SRA arithmetic A >>> B[4:0] with sign fill. B[31:5] is ignored for shifts.
  - XOR/OR/AND are bitwise. COPY_B gives B. NOP gives 0.
- Latency: Out, Zero and ALUop are purely combinational, with zero cycles from any input change.
- Registers: OutReg/ZeroReg capture Out/Zero on every rising Clock edge.
- Reset: while Reset=1, OutReg=0 and ZeroReg=1 (consistent with a zero result), asynchronously and regardless of Clock. Reset does not affect the combinational outputs. On deassertion, the first rising edge loads the current result.
- No handshake; the block computes every cycle.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: SLL/SRL/SRA are implemented as above.
- Undefined: the decoder maps all shift encodings to NOP (ALUop=15, Out=0, Zero=1) and no barrel shifter is synthesized. All other ops are unchanged.

Decomposition:
- Shared package holds:
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_ARI_ITYPE, OPC_ARI_RTYPE);
  - funct3 constants (FNC_ADD_SUB, FNC_SLL, FNC_SLT, FNC_SLTU, FNC_XOR, FNC_SRL_SRA, FNC_OR, FNC_AND);
  - FNC2_SRL=0 and FNC2_SRA=1;
  - the 4-bit ALUop enumeration.
- One sub-module, alu_op_decoder (purely combinational opcode/funct -> ALUop); the datapath and output register stay in the top.

Test Plan:
- A=0x80000005, B=0xFFFF8003:
  - ARI_RTYPE funct3 000, bit30=0 -> Out=0x7FFF8008.
  - bit30=1 -> Out=0x80008002.
  - ARI_ITYPE funct3 000, bit30=1 -> Out=0x7FFF8008 (still ADD).
- Same A/B:
  - SLT -> Out=1; SLTU -> Out=1.
  - A=0x00000001, B=0xFFFFFFFF: SLT -> 0, SLTU -> 1.
- LUI, A=0x12345678, B=0xABCDE000, random funct/bit30 -> Out=0xABCDE000, ALUop=10. AUIPC/LOAD/STORE/BRANCH/JALR with the same operands -> Out=0xBE0236 78... i.e. A+B = 0xBE023678 (mod 2^32).
- Shifts with ALU_SHIFT_EN, A=0xF000FFFF, B=0x0000000F:
  - SRA -> 0xFFFFE001; SRL -> 0x0001E001; SLL -> 0x7FFF8000.
  - B=0xFFFFFFEF (shamt 15) gives identical results.
  - Without the macro: Out=0, Zero=1.
- Zero and register timing:
  - XOR with A=B=0x5A5A5A5A -> Out=0, Zero=1 immediately; OutReg=0 / ZeroReg=1 after the next rising edge.
  - Change to OR -> OutReg=0x5A5A5A5A one edge later.
- Reset: assert Reset mid-cycle while OutReg=0x5A5A5A5A -> OutReg=0 and ZeroReg=1 with no Clock edge; Out still tracks inputs. Unknown opcode 1111111 -> ALUop=15, Out=0.
